// File: rtl/ara_pe_issue_queue.sv
// Per-PE in-order issue queue: buffers sequencer requests for one VFU group and
// releases the head once its hazards clear. Optional: ARA_ISSUE_QUEUE_CHAINING_EN.
package ara_pe_issue_queue_pkg;
  localparam int unsigned NrVInsn = 8;
  localparam int unsigned IdW     = $clog2(NrVInsn);

  typedef enum logic [2:0] {
    VFU_None,
    VFU_Alu,
    VFU_MFpu,
    VFU_SlideUnit,
    VFU_MaskUnit,
    VFU_LoadUnit,
    VFU_StoreUnit
  } vfu_e;

  typedef struct packed {
    logic [IdW-1:0]     id;
    vfu_e               vfu;
    logic [7:0]         op;
    logic [NrVInsn-1:0] hazard_vs1;
    logic [NrVInsn-1:0] hazard_vs2;
    logic [NrVInsn-1:0] hazard_vm;
    logic [NrVInsn-1:0] hazard_vd;
  } pe_req_t;
endpackage

module ara_pe_issue_queue
  import ara_pe_issue_queue_pkg::*;
#(
  parameter int unsigned NrVInsn    = ara_pe_issue_queue_pkg::NrVInsn,
  parameter int unsigned Depth      = 4,
  parameter vfu_e        AcceptVfu0 = VFU_Alu,
  parameter vfu_e        AcceptVfu1 = VFU_MFpu
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  pe_req_t            pe_req_i,
  input  logic               pe_req_valid_i,
  output logic               pe_req_ready_o,
  input  logic [NrVInsn-1:0] vinsn_done_i,
  output pe_req_t            issue_req_o,
  output logic               issue_valid_o,
  input  logic               issue_ready_i,
  output logic [NrVInsn-1:0] queued_vinsn_o,
  output logic               empty_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic [Depth-1:0] valid_q;
  pe_req_t         mem [Depth];
  pe_req_t         head;
  logic            match, push, pop, blocked;

  always_comb begin
    head           = mem[rd_ptr];
    pe_req_ready_o = (count != CntW'(Depth));
    match          = (pe_req_i.vfu == AcceptVfu0) || (pe_req_i.vfu == AcceptVfu1);
    push           = pe_req_valid_i && pe_req_ready_o && match;
    empty_o        = (count == '0);
`ifdef ARA_ISSUE_QUEUE_CHAINING_EN
    // Source-operand hazards are resolved downstream by operand chaining.
    blocked        = |head.hazard_vd;
`else
    blocked        = |(head.hazard_vs1 | head.hazard_vs2 | head.hazard_vm | head.hazard_vd);
`endif
    issue_valid_o  = !empty_o && !blocked;
    issue_req_o    = empty_o ? '0 : head;
    pop            = issue_valid_o && issue_ready_i;
  end

  always_comb begin
    queued_vinsn_o = '0;
    for (int i = 0; i < Depth; i++) begin
      if (valid_q[i]) queued_vinsn_o |= {{(NrVInsn-1){1'b0}}, 1'b1} << mem[i].id;
    end
  end

  // NOTE: the payload array carries no reset; valid_q and count alone define
  // which entries are live, and outputs are gated on them.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      mem[i].hazard_vs1 <= mem[i].hazard_vs1 & ~vinsn_done_i;
      mem[i].hazard_vs2 <= mem[i].hazard_vs2 & ~vinsn_done_i;
      mem[i].hazard_vm  <= mem[i].hazard_vm  & ~vinsn_done_i;
      mem[i].hazard_vd  <= mem[i].hazard_vd  & ~vinsn_done_i;
    end
    if (push) begin
      // Mask on write so a completion coinciding with the accept is not lost.
      mem[wr_ptr]            <= pe_req_i;
      mem[wr_ptr].hazard_vs1 <= pe_req_i.hazard_vs1 & ~vinsn_done_i;
      mem[wr_ptr].hazard_vs2 <= pe_req_i.hazard_vs2 & ~vinsn_done_i;
      mem[wr_ptr].hazard_vm  <= pe_req_i.hazard_vm  & ~vinsn_done_i;
      mem[wr_ptr].hazard_vd  <= pe_req_i.hazard_vd  & ~vinsn_done_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + PtrW'(1);
        valid_q[wr_ptr] <= 1'b1;
      end
      // Push and pop never share a slot: that would need count of 0 or Depth.
      if (pop) begin
        rd_ptr          <= rd_ptr + PtrW'(1);
        valid_q[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ara_pe_issue_queue.sv
// Scoreboard bench for ara_pe_issue_queue: accepted requests are queued as
// expectations and compared in order as the FU side pops them.
module tb_ara_pe_issue_queue;
  import ara_pe_issue_queue_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  pe_req_t      pe_req_i;
  logic         pe_req_valid_i;
  logic         pe_req_ready_o;
  logic [7:0]   vinsn_done_i;
  pe_req_t      issue_req_o;
  logic         issue_valid_o;
  logic         issue_ready_i;
  logic [7:0]   queued_vinsn_o;
  logic         empty_o;

  int checks   = 0;
  int failures = 0;
  pe_req_t sb[$];

  ara_pe_issue_queue dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .pe_req_i       (pe_req_i),
    .pe_req_valid_i (pe_req_valid_i),
    .pe_req_ready_o (pe_req_ready_o),
    .vinsn_done_i   (vinsn_done_i),
    .issue_req_o    (issue_req_o),
    .issue_valid_o  (issue_valid_o),
    .issue_ready_i  (issue_ready_i),
    .queued_vinsn_o (queued_vinsn_o),
    .empty_o        (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic pe_req_t mk(input int id, input vfu_e vfu, input int op,
                                 input logic [7:0] hvs1, input logic [7:0] hvd);
    pe_req_t r;
    r            = '0;
    r.id         = 3'(id);
    r.vfu        = vfu;
    r.op         = 8'(op);
    r.hazard_vs1 = hvs1;
    r.hazard_vd  = hvd;
    return r;
  endfunction

  function automatic bit accepted_vfu(input vfu_e v);
    return (v == VFU_Alu) || (v == VFU_MFpu);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request for exactly one cycle (caller has checked ready = 1).
  task automatic push_one(input pe_req_t r);
    pe_req_i       = r;
    pe_req_valid_i = 1'b1;
    if (accepted_vfu(r.vfu)) sb.push_back(r);
    tick();
    pe_req_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    issue_ready_i = 1'b1;
    while (!empty_o && n < 50) begin
      tick();
      n++;
    end
    check(tag, empty_o, 1);
    issue_ready_i = 1'b0;
  endtask

  // Pop-side scoreboard: a handshake seen mid-cycle is consumed at the next edge.
  always @(negedge clk_i) begin
    if (rst_ni && issue_valid_o && issue_ready_i) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        pe_req_t e;
        e = sb.pop_front();
        check("pop_id", issue_req_o.id, e.id);
        check("pop_op", issue_req_o.op, e.op);
        check("pop_vfu", issue_req_o.vfu, e.vfu);
      end
    end
  end

  initial begin
    pe_req_t wrap_list [4];
    int idx;
    int guard;

    rst_ni         = 1'b0;
    pe_req_i       = '0;
    pe_req_valid_i = 1'b0;
    vinsn_done_i   = '0;
    issue_ready_i  = 1'b0;
    #12;
    check("rst_ready", pe_req_ready_o, 1);
    check("rst_empty", empty_o, 1);
    check("rst_issue_valid", issue_valid_o, 0);
    check("rst_issue_req", issue_req_o, 0);
    check("rst_queued", queued_vinsn_o, 0);
    rst_ni = 1'b1;
    tick();

    // Basic ALU request, zero hazards: issues the cycle after accept.
    pe_req_i       = mk(2, VFU_Alu, 8'h11, 8'h00, 8'h00);
    pe_req_valid_i = 1'b1;
    check("t1_ready", pe_req_ready_o, 1);
    push_one(mk(2, VFU_Alu, 8'h11, 8'h00, 8'h00));
    check("t1_issue_valid", issue_valid_o, 1);
    check("t1_issue_id", issue_req_o.id, 2);
    check("t1_queued", queued_vinsn_o, 8'b0000_0100);
    drain("t1_drain");

    // Non-matching VFU: handshaken and discarded.
    pe_req_i       = mk(3, VFU_LoadUnit, 8'h22, 8'h00, 8'h00);
    pe_req_valid_i = 1'b1;
    check("t2_ready", pe_req_ready_o, 1);
    push_one(mk(3, VFU_LoadUnit, 8'h22, 8'h00, 8'h00));
    check("t2_empty", empty_o, 1);
    check("t2_issue_valid", issue_valid_o, 0);
    tick();
    check("t2_empty_later", empty_o, 1);

    // RAW hazard on vs1 cleared by a completion pulse.
    issue_ready_i = 1'b1;
    push_one(mk(1, VFU_MFpu, 8'h33, 8'b0000_1000, 8'h00));
    check("t3_hz_shown", issue_req_o.hazard_vs1, 8'b0000_1000);
`ifdef ARA_ISSUE_QUEUE_CHAINING_EN
    check("t3_issue_chain", issue_valid_o, 1);
    tick();
    check("t3_empty_chain", empty_o, 1);
`else
    check("t3_blocked0", issue_valid_o, 0);
    tick();
    check("t3_blocked1", issue_valid_o, 0);
    vinsn_done_i = 8'b0000_1000;
    tick();
    vinsn_done_i = '0;
    check("t3_issue_after_done", issue_valid_o, 1);
    check("t3_hz_cleared", issue_req_o.hazard_vs1, 0);
    tick();
    check("t3_empty", empty_o, 1);
`endif
    issue_ready_i = 1'b0;

    // Fill to Depth, then pop with pushes pending across pointer wrap.
    for (int k = 0; k < 4; k++) begin
      check("t4_ready_fill", pe_req_ready_o, 1);
      push_one(mk(3 + k, (k % 2 == 0) ? VFU_Alu : VFU_MFpu, 8'h40 + k, 8'h00, 8'h00));
    end
    check("t4_full_ready", pe_req_ready_o, 0);
    check("t4_full_queued", queued_vinsn_o, 8'b0111_1000);
    wrap_list[0] = mk(7, VFU_Alu, 8'h50, 8'h00, 8'h00);
    wrap_list[1] = mk(5, VFU_LoadUnit, 8'h51, 8'h00, 8'h00);
    wrap_list[2] = mk(0, VFU_MFpu, 8'h52, 8'h00, 8'h00);
    wrap_list[3] = mk(2, VFU_Alu, 8'h53, 8'h00, 8'h00);
    issue_ready_i  = 1'b1;
    pe_req_i       = wrap_list[0];
    pe_req_valid_i = 1'b1;
    tick();
    check("t4_ready_after_pop", pe_req_ready_o, 1);
    idx   = 0;
    guard = 0;
    while (idx < 4 && guard < 20) begin
      pe_req_i = wrap_list[idx];
      if (pe_req_ready_o) begin
        if (accepted_vfu(wrap_list[idx].vfu)) sb.push_back(wrap_list[idx]);
        idx++;
      end
      tick();
      guard++;
    end
    pe_req_valid_i = 1'b0;
    check("t4_all_sent", idx, 4);
    drain("t4_drain");

    // Completion in the same cycle as the write of a WAW hazard.
    pe_req_i       = mk(4, VFU_MFpu, 8'h60, 8'h00, 8'b0010_0000);
    vinsn_done_i   = 8'b0010_0000;
    push_one(mk(4, VFU_MFpu, 8'h60, 8'h00, 8'b0010_0000));
    vinsn_done_i   = '0;
    check("t5_hz_vd", issue_req_o.hazard_vd, 0);
    check("t5_issue_valid", issue_valid_o, 1);
    drain("t5_drain");

    // Asynchronous reset with three entries held.
    push_one(mk(1, VFU_Alu, 8'h70, 8'h00, 8'h00));
    push_one(mk(3, VFU_Alu, 8'h71, 8'h00, 8'h00));
    push_one(mk(6, VFU_MFpu, 8'h72, 8'h00, 8'h00));
    check("t6_queued", queued_vinsn_o, 8'b0100_1010);
    check("t6_not_empty", empty_o, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_empty", empty_o, 1);
    check("t6_rst_issue_valid", issue_valid_o, 0);
    check("t6_rst_queued", queued_vinsn_o, 0);
    check("t6_rst_ready", pe_req_ready_o, 1);
    sb.delete();
    #10;
    rst_ni = 1'b1;
    tick();
    tick();
    check("t6_post_rst_empty", empty_o, 1);

    check("sb_leftover", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
